// File: rtl/s2p_frame_controller.sv
// s2p_frame_controller: framed serial-to-parallel capture with a word FIFO.
// Build option: define S2P_PARITY_EN to consume an even-parity bit per word.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cfg_width[4:0]        bits per word (0 means 32), latched at start
//   cfg_words[WORDS_W-1:0] words per frame (0 means 2^WORDS_W), latched at start
//   start                 frame start pulse, honoured only when idle
//   serial_in/valid       serial bit and its qualifier (LSB first)
//   out_data[31:0]        FIFO head word, upper unused bits zero
//   out_valid/out_ready   store handshake on the FIFO head
//   out_last              head word is the last word of its frame
//   busy                  frame in progress (receiving or draining)
//   frame_done            one-cycle pulse when the drained frame returns to idle
//   overflow              sticky: a word was dropped because the FIFO was full
//   parity_error          (S2P_PARITY_EN only) sticky parity mismatch flag
module s2p_frame_controller #(
    parameter int FIFO_DEPTH = 4,
    parameter int WORDS_W    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [4:0]         cfg_width,
    input  logic [WORDS_W-1:0] cfg_words,
    input  logic               start,
    input  logic               serial_in,
    input  logic               serial_valid,
    output logic [31:0]        out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic               frame_done,
`ifdef S2P_PARITY_EN
    output logic               parity_error,
`endif
    output logic               overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]         state;
    logic [4:0]         width_m1;
    logic [WORDS_W-1:0] words_m1;
    logic [4:0]         bit_cnt;
    logic [WORDS_W-1:0] word_cnt;
    logic [31:0]        shift_q;
    logic               overflow_q;
    logic               frame_done_q;

    logic [31:0]        mem_data [FIFO_DEPTH];
    logic               mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               fifo_empty;
    logic               fifo_full;
    logic               pop;
    logic               bit_take;
    logic               data_end;
    logic               push_req;
    logic               push_ok;
    logic               drop;
    logic               is_last;
    logic [31:0]        word_next;
    logic [31:0]        push_word;

`ifdef S2P_PARITY_EN
    logic               par_phase;
    logic               par_err_q;
    logic               par_bad;
`endif

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && out_ready;
    assign bit_take   = (state == ST_RECV) && serial_valid;
    assign is_last    = (word_cnt == words_m1);

    // Shift register with the current bit merged in; bits above the
    // configured width are never written, so they stay zero.
    always_comb begin
        word_next = shift_q;
        word_next[bit_cnt] = serial_in;
    end

`ifdef S2P_PARITY_EN
    assign data_end  = bit_take && !par_phase && (bit_cnt == width_m1);
    assign push_req  = bit_take && par_phase;
    assign push_word = shift_q;
    assign par_bad   = (serial_in != (^shift_q));
`else
    assign data_end  = bit_take && (bit_cnt == width_m1);
    assign push_req  = data_end;
    assign push_word = word_next;
`endif

    // A pop in the same cycle frees the slot, so a full FIFO still
    // accepts the push.
    assign push_ok = push_req && (!fifo_full || pop);
    assign drop    = push_req && fifo_full && !pop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            width_m1     <= '0;
            words_m1     <= '0;
            bit_cnt      <= '0;
            word_cnt     <= '0;
            shift_q      <= '0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef S2P_PARITY_EN
            par_phase    <= 1'b0;
            par_err_q    <= 1'b0;
`endif
        end else begin
            frame_done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Minus-one forms make 0 wrap to the maximum.
                        width_m1   <= cfg_width - 5'd1;
                        words_m1   <= cfg_words - WORDS_W'(1);
                        bit_cnt    <= '0;
                        word_cnt   <= '0;
                        shift_q    <= '0;
                        overflow_q <= 1'b0;
`ifdef S2P_PARITY_EN
                        par_phase  <= 1'b0;
                        par_err_q  <= 1'b0;
`endif
                        state      <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (drop) begin
                        overflow_q <= 1'b1;
                    end
                    if (push_req) begin
                        // Dropped words still count toward the frame.
                        shift_q  <= '0;
                        bit_cnt  <= '0;
                        word_cnt <= word_cnt + WORDS_W'(1);
                        if (is_last) begin
                            state <= ST_DRAIN;
                        end
`ifdef S2P_PARITY_EN
                        par_phase <= 1'b0;
                        if (par_bad) begin
                            par_err_q <= 1'b1;
                        end
                    end else if (data_end) begin
                        shift_q   <= word_next;
                        bit_cnt   <= '0;
                        par_phase <= 1'b1;
`endif
                    end else if (bit_take) begin
                        shift_q <= word_next;
                        bit_cnt <= bit_cnt + 5'd1;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty) begin
                        state        <= ST_IDLE;
                        frame_done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_data[wr_ptr] <= push_word;
            mem_last[wr_ptr] <= is_last;
        end
    end

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? 32'd0 : mem_data[rd_ptr];
    assign out_last   = fifo_empty ? 1'b0 : mem_last[rd_ptr];
    assign busy       = (state != ST_IDLE);
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
`ifdef S2P_PARITY_EN
    assign parity_error = par_err_q;
`endif

endmodule

// File: tb/tb_s2p_frame_controller.sv
// tb_s2p_frame_controller: directed checks of framing, FIFO, overflow,
// reset and ignored-input behaviour of s2p_frame_controller.
module tb_s2p_frame_controller;

    logic        clock;
    logic        reset;
    logic [4:0]  cfg_width;
    logic [7:0]  cfg_words;
    logic        start;
    logic        serial_in;
    logic        serial_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        frame_done;
    logic        overflow;
`ifdef S2P_PARITY_EN
    logic        parity_error;
`endif

    int checks = 0;
    int errors = 0;

    s2p_frame_controller #(.FIFO_DEPTH(4), .WORDS_W(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_width    (cfg_width),
        .cfg_words    (cfg_words),
        .start        (start),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_last     (out_last),
        .busy         (busy),
        .frame_done   (frame_done),
`ifdef S2P_PARITY_EN
        .parity_error (parity_error),
`endif
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // All stimulus changes at the falling edge; outputs are read there too.
    task automatic bit_cycle(input logic b, input logic v);
        serial_in    = b;
        serial_valid = v;
        @(negedge clock);
        serial_valid = 1'b0;
        serial_in    = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            bit_cycle(w[i], 1'b1);
        end
`ifdef S2P_PARITY_EN
        bit_cycle(^w, 1'b1);
`endif
    endtask

    task automatic do_start(input logic [4:0] w, input logic [7:0] n);
        cfg_width = w;
        cfg_words = n;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({out_valid, out_last, busy, frame_done, overflow} !== 5'b0 ||
            out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got v%b l%b b%b fd%b ov%b d%h want all 0",
                     out_valid, out_last, busy, frame_done, overflow, out_data);
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        do_start(5'd8, 8'd2);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        send_word(32'hA5, 8);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL basic_w0: got v%b d%h l%b want v1 d000000a5 l0",
                     out_valid, out_data, out_last);
        end
        send_word(32'h3C, 8);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h3C || out_last !== 1'b1) begin
            errors++;
            $display("FAIL basic_w1: got v%b d%h l%b want v1 d0000003c l1",
                     out_valid, out_data, out_last);
        end
`ifdef S2P_PARITY_EN
        checks++;
        if (parity_error !== 1'b0) begin
            errors++;
            $display("FAIL basic_parity: got %b want 0", parity_error);
        end
`endif
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_drain: got v%b fd%b b%b want v0 fd0 b1",
                     out_valid, frame_done, busy);
        end
        @(negedge clock);
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got fd%b b%b want fd1 b0", frame_done, busy);
        end
        @(negedge clock);
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse: got fd%b want 0", frame_done);
        end
    endtask

    task automatic test_width32_stall;
        logic [31:0] d;
        d = 32'hDEADBEEF;
        out_ready = 1'b1;
        do_start(5'd0, 8'd1);
        for (int i = 0; i < 31; i++) begin
            bit_cycle(d[i], 1'b1);
            bit_cycle(1'b0, 1'b0);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL w32_partial: got v%b d%h want v0", out_valid, out_data);
        end
        bit_cycle(d[31], 1'b1);
`ifdef S2P_PARITY_EN
        bit_cycle(1'b0, 1'b0);
        bit_cycle(^d, 1'b1);
`endif
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_last !== 1'b1) begin
            errors++;
            $display("FAIL w32_word: got v%b d%h l%b want v1 ddeadbeef l1",
                     out_valid, out_data, out_last);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (frame_done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL w32_done: got fd%b v%b want fd1 v0", frame_done, out_valid);
        end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        do_start(5'd4, 8'd6);
        for (int k = 1; k <= 6; k++) begin
            send_word(32'(k), 4);
            if (k == 4) begin
                checks++;
                if (overflow !== 1'b0 || out_data !== 32'd1) begin
                    errors++;
                    $display("FAIL ovf_fill: got ov%b d%h want ov0 d1", overflow, out_data);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b1 || out_data !== 32'd1) begin
            errors++;
            $display("FAIL ovf_flag: got ov%b b%b d%h want ov1 b1 d1",
                     overflow, busy, out_data);
        end
        for (int k = 1; k <= 4; k++) begin
            out_ready = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== 32'(k) || out_last !== 1'b0) begin
                errors++;
                $display("FAIL ovf_pop%0d: got v%b d%h l%b want v1 d%h l0",
                         k, out_valid, out_data, out_last, 32'(k));
            end
            @(negedge clock);
        end
        checks++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: got v%b fd%b want v0 fd0", out_valid, frame_done);
        end
        @(negedge clock);
        checks++;
        if (frame_done !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_done: got fd%b ov%b want fd1 ov1", frame_done, overflow);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_full_push_pop;
        out_ready = 1'b0;
        do_start(5'd4, 8'd5);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_clear: got ov%b want 0", overflow);
        end
        for (int k = 1; k <= 4; k++) begin
            send_word(32'(k), 4);
        end
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b0, 1'b1);
        bit_cycle(1'b1, 1'b1);
`ifdef S2P_PARITY_EN
        bit_cycle(1'b0, 1'b1);
        out_ready = 1'b1;
        bit_cycle(1'b0, 1'b1);
`else
        out_ready = 1'b1;
        bit_cycle(1'b0, 1'b1);
`endif
        out_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd2) begin
            errors++;
            $display("FAIL fpp_push: got ov%b v%b d%h want ov0 v1 d2",
                     overflow, out_valid, out_data);
        end
        for (int k = 2; k <= 5; k++) begin
            out_ready = 1'b1;
            checks++;
            if (out_data !== 32'(k) || out_last !== (k == 5)) begin
                errors++;
                $display("FAIL fpp_pop%0d: got d%h l%b want d%h l%b",
                         k, out_data, out_last, 32'(k), (k == 5));
            end
            @(negedge clock);
        end
        @(negedge clock);
        checks++;
        if (frame_done !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fpp_done: got fd%b ov%b want fd1 ov0", frame_done, overflow);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_mid_reset;
        out_ready = 1'b0;
        do_start(5'd8, 8'd2);
        send_word(32'h5A, 8);
        for (int i = 0; i < 5; i++) begin
            bit_cycle(1'b1, 1'b1);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({out_valid, out_last, busy, frame_done, overflow} !== 5'b0 ||
            out_data !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: got v%b l%b b%b fd%b ov%b d%h want all 0",
                     out_valid, out_last, busy, frame_done, overflow, out_data);
        end
        do_start(5'd8, 8'd1);
        send_word(32'h81, 8);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h81 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_word: got v%b d%h l%b want v1 d00000081 l1",
                     out_valid, out_data, out_last);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if (frame_done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_done: got fd%b v%b want fd1 v0", frame_done, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_ignored_inputs;
        out_ready = 1'b0;
        do_start(5'd8, 8'd2);
        send_word(32'h11, 8);
        cfg_width = 5'd4;
        cfg_words = 8'd1;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        send_word(32'h22, 8);
        checks++;
        if (busy !== 1'b1 || out_data !== 32'h11) begin
            errors++;
            $display("FAIL ign_drain: got b%b d%h want b1 d00000011", busy, out_data);
        end
        send_word(32'hFF, 8);
        for (int k = 0; k < 2; k++) begin
            out_ready = 1'b1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== (k == 0 ? 32'h11 : 32'h22) ||
                out_last !== (k == 1)) begin
                errors++;
                $display("FAIL ign_pop%0d: got v%b d%h l%b want v1 d%h l%b", k,
                         out_valid, out_data, out_last,
                         (k == 0 ? 32'h11 : 32'h22), (k == 1));
            end
            @(negedge clock);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ign_extra: got v%b d%h want v0", out_valid, out_data);
        end
        @(negedge clock);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL ign_done: got fd%b want 1", frame_done);
        end
        out_ready = 1'b0;
    endtask

`ifdef S2P_PARITY_EN
    task automatic test_parity;
        out_ready = 1'b0;
        do_start(5'd4, 8'd1);
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b1, 1'b1);
        bit_cycle(1'b0, 1'b1);
        bit_cycle(1'b0, 1'b1);
        checks++;
        if (parity_error !== 1'b1 || out_data !== 32'd7 || out_last !== 1'b1) begin
            errors++;
            $display("FAIL par_bad: got pe%b d%h l%b want pe1 d7 l1",
                     parity_error, out_data, out_last);
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        out_ready = 1'b0;
        do_start(5'd4, 8'd1);
        checks++;
        if (parity_error !== 1'b0) begin
            errors++;
            $display("FAIL par_clear: got pe%b want 0", parity_error);
        end
        send_word(32'd3, 4);
        out_ready = 1'b1;
        repeat (3) @(negedge clock);
        out_ready = 1'b0;
    endtask
`endif

    initial begin
        reset        = 1'b1;
        cfg_width    = '0;
        cfg_words    = '0;
        start        = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        out_ready    = 1'b0;
        test_reset();
        test_basic();
        test_width32_stall();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_ignored_inputs();
`ifdef S2P_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
